dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache that sits directly
//  upstream of datamem: CPU load/store port in front, datamem port behind.
//  A cache line is two consecutive blocks, matching datamem's out1/out2
//  pair read. Refill is one datamem read. Dirty eviction is two datamem
//  block writes (block 0, then block 1).
// PARAMETERS
//  WORD_SIZE   32  address width (byte address, same as datamem 'in')
//  BLOCK_SIZE  32  CPU data / datamem block width, bits; BB = BLOCK_SIZE/8 bytes
//  INDEX_BITS  4   log2(number of lines); LINES = 2**INDEX_BITS
//  Line = 2*BB bytes. addr fields: [log2(BB)-1:0] ignored | [log2(BB)] blk
//  | next INDEX_BITS = index | remaining upper bits = tag.
// PORTS
//  clk          in   1           clock, all state on posedge
//  rst_n        in   1           async active-low reset
//  cpu_req      in   1           access request, held until cpu_ready
//  cpu_we       in   1           1 = store, 0 = load
//  cpu_addr     in   WORD_SIZE   byte address
//  cpu_wdata    in   BLOCK_SIZE  store data
//  cpu_rdata    out  BLOCK_SIZE  load data, valid when cpu_ready & ~cpu_we
//  cpu_ready    out  1           access completes this cycle
//  mem_addr     out  WORD_SIZE   to datamem 'in'
//  mem_writable out  1           to datamem 'writable' (1 = write)
//  mem_write    out  BLOCK_SIZE  to datamem 'write'
//  mem_out1     in   BLOCK_SIZE  datamem block at mem_addr
//  mem_out2     in   BLOCK_SIZE  datamem block at mem_addr+BB
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all valid and dirty bits=0;
//   mem_addr=0, mem_writable=0, mem_write=0. Data and tag arrays are not
//   reset. cpu_ready=0 and cpu_rdata=0 whenever rst_n=0.
//  datamem timing: an address driven in cycle N with writable=0 gives
//   out1/out2 in cycle N+1. With writable=1, the write commits at the end
//   of cycle N.
//  IDLE: hit = cpu_req & valid[idx] & tag match.
//   Hit: cpu_ready=1 combinationally in the same cycle.
//    Load: cpu_rdata = line block blk.
//    Store: block blk <= cpu_wdata and dirty[idx] <= 1 at the posedge.
//   Miss: latch cpu_addr into miss_addr. Go to WB0 if valid&dirty,
//    else to FILL. cpu_ready=0.
//   No req: cpu_ready=0, mem_writable=0.
//  WB0: mem_writable=1, mem_addr={old tag,idx,blk=0,0s}, mem_write=block0.
//   Next state: WB1.
//  WB1: mem_writable=1, mem_addr=WB0 address+BB, mem_write=block1.
//   Next state: FILL.
//  FILL: mem_writable=0, mem_addr=miss_addr with blk and low bits cleared.
//   Next state: WAIT.
//  WAIT: block0<=mem_out1, block1<=mem_out2, tag<=miss tag,
//   valid<=1, dirty<=0. Next state: IDLE.
//  After WAIT, IDLE re-evaluates the request and hits.
//  Miss latency, counted from the miss cycle:
//   clean miss: cpu_ready in cycle 3. Dirty miss: cpu_ready in cycle 5.
//  mem_writable=1 only in WB0/WB1.
//  CPU must hold cpu_addr, cpu_we and cpu_wdata stable until cpu_ready.
//   WB and FILL addresses come from the latched values, not from live inputs.
//  Store miss: allocate the line, then write on the IDLE hit. Never write-through.
//  Reset mid-WB or mid-FILL: abort immediately; all lines become invalid;
//   dirty data not yet written is lost; the partial memory line may be stale.
//  cpu_req=0 while the FSM is in WB/FILL/WAIT: the sequence still completes.
// TESTING (BLOCK_SIZE=32, INDEX_BITS=4; 0x40/0x44/0xC0/0xC4 all index 8)
//  1 Cold load: reset, datamem 0x40..0x47 = 11223344_55667788, load 0x40
//    -> FILL in cycle 1 with mem_addr=0x40, writable=0; cpu_ready in cycle 3;
//    cpu_rdata=0x11223344.
//  2 Same-line load 0x44 after test 1
//    -> cpu_ready in the same cycle, rdata=0x55667788, no mem activity.
//  3 Store hit 0x44 with 0xDEADBEEF, then load 0x44
//    -> 0xDEADBEEF; dirty[8]=1; mem_writable stays 0.
//  4 Dirty evict: after test 3, load 0xC0
//    -> WB0 writes 0x40 <= 0x11223344, WB1 writes 0x44 <= 0xDEADBEEF,
//    FILL reads 0xC0; cpu_ready in cycle 5. Reload 0x44: clean miss, returns 0xDEADBEEF.
//  5 Clean evict: load 0x40 (clean), then load 0xC4
//    -> no writable=1 cycle; rdata = mem_out2; ready in cycle 3.
//  6 rst_n=0 during WB1
//    -> mem_writable=0 at once; after release, load 0xC0 misses and
//    goes straight to FILL.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache in front of datamem.
// A line is two blocks; refill is one paired read, dirty eviction is two block writes.
module dcache_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [WORD_SIZE-1:0]  i_cpu_addr,
  input  logic [BLOCK_SIZE-1:0] i_cpu_wdata,
  output logic [BLOCK_SIZE-1:0] o_cpu_rdata,
  output logic                  o_cpu_ready,
  output logic [WORD_SIZE-1:0]  o_mem_addr,
  output logic                  o_mem_writable,
  output logic [BLOCK_SIZE-1:0] o_mem_write,
  input  logic [BLOCK_SIZE-1:0] i_mem_out1,
  input  logic [BLOCK_SIZE-1:0] i_mem_out2
);
  localparam int BB    = BLOCK_SIZE / 8;
  localparam int OFF   = $clog2(BB);
  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TW    = WORD_SIZE - OFF - 1 - INDEX_BITS;
  localparam logic [WORD_SIZE-1:0] LMASK = WORD_SIZE'(2 * BB - 1);

  typedef enum logic [2:0] {IDLE, WB0, WB1, FILL, WAIT} state_t;

  state_t                r_state;
  logic [BLOCK_SIZE-1:0] r_blk0 [LINES];
  logic [BLOCK_SIZE-1:0] r_blk1 [LINES];
  logic [TW-1:0]         r_tag  [LINES];
  logic [LINES-1:0]      r_valid, r_dirty;
  logic [WORD_SIZE-1:0]  r_miss_addr, r_mem_addr;
  logic                  r_mem_writable;
  logic [BLOCK_SIZE-1:0] r_mem_write;

  logic [INDEX_BITS-1:0] w_idx, w_midx;
  logic [TW-1:0]         w_tag, w_mtag;
  logic                  w_blk, w_hit, w_miss;
  logic [WORD_SIZE-1:0]  w_line_addr;

  assign w_idx       = i_cpu_addr[OFF+1 +: INDEX_BITS];
  assign w_blk       = i_cpu_addr[OFF];
  assign w_tag       = i_cpu_addr[WORD_SIZE-1 -: TW];
  assign w_line_addr = i_cpu_addr & ~LMASK;
  assign w_midx      = r_miss_addr[OFF+1 +: INDEX_BITS];
  assign w_mtag      = r_miss_addr[WORD_SIZE-1 -: TW];
  assign w_hit       = r_state == IDLE && i_cpu_req && r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_miss      = r_state == IDLE && i_cpu_req && !w_hit;

  assign o_cpu_ready    = rst_n && w_hit;
  assign o_cpu_rdata    = (rst_n && w_hit) ? (w_blk ? r_blk1[w_idx] : r_blk0[w_idx]) : '0;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_writable = r_mem_writable;
  assign o_mem_write    = r_mem_write;

  // Line storage carries no reset; valid bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (r_state == WAIT) begin
      r_blk0[w_midx] <= i_mem_out1;
      r_blk1[w_midx] <= i_mem_out2;
      r_tag[w_midx]  <= w_mtag;
    end else if (w_hit && i_cpu_we) begin
      if (w_blk) r_blk1[w_idx] <= i_cpu_wdata;
      else r_blk0[w_idx] <= i_cpu_wdata;
    end
  end

  // Memory-side outputs are registered, so each is loaded for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_valid        <= '0;
      r_dirty        <= '0;
      r_miss_addr    <= '0;
      r_mem_addr     <= '0;
      r_mem_writable <= 1'b0;
      r_mem_write    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_mem_writable <= 1'b0;
          if (w_hit && i_cpu_we) r_dirty[w_idx] <= 1'b1;
          if (w_miss) begin
            r_miss_addr <= w_line_addr;
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state        <= WB0;
              r_mem_writable <= 1'b1;
              r_mem_addr     <= {r_tag[w_idx], w_idx, {(OFF + 1){1'b0}}};
              r_mem_write    <= r_blk0[w_idx];
            end else begin
              r_state    <= FILL;
              r_mem_addr <= w_line_addr;
            end
          end
        end
        WB0: begin
          r_state     <= WB1;
          r_mem_addr  <= r_mem_addr + WORD_SIZE'(BB);
          r_mem_write <= r_blk1[w_midx];
        end
        WB1: begin
          r_state        <= FILL;
          r_mem_writable <= 1'b0;
          r_mem_addr     <= r_miss_addr;
        end
        FILL: r_state <= WAIT;
        WAIT: begin
          r_state         <= IDLE;
          r_valid[w_midx] <= 1'b1;
          r_dirty[w_midx] <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed table of cache accesses against a small datamem model,
// plus hand sequences for reset during write-back and request drop mid-miss.
module tb_dcache_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, tb_init = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata, mem_addr, mem_write, mem_out1, mem_out2;
  logic        cpu_ready, mem_writable;
  logic [31:0] mem [256];
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    int          lat;
    logic [31:0] rd, a1;
    logic        wb, pc;
    logic [31:0] paddr, pval;
  } vec_t;
  vec_t tbl[14];

  dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata),
    .o_cpu_ready(cpu_ready), .o_mem_addr(mem_addr), .o_mem_writable(mem_writable),
    .o_mem_write(mem_write), .i_mem_out1(mem_out1), .i_mem_out2(mem_out2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    logic [31:0] a;
    a = 32'(i * 4);
    if (a == 32'h40) return 32'h11223344;
    if (a == 32'h44) return 32'h55667788;
    if (a == 32'hC0) return 32'hAAAA0000;
    if (a == 32'hC4) return 32'hBBBB1111;
    return 32'hA0000000 | a;
  endfunction

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_writable) mem[mem_addr[9:2]] <= mem_write;
      mem_out1 <= mem[mem_addr[9:2]];
      mem_out2 <= mem[mem_addr[9:2] + 8'd1];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic access(input vec_t v, input string nm);
    logic        done, seen_wb;
    logic [31:0] a1, rd;
    int          lat;
    done = 1'b0; seen_wb = 1'b0; a1 = '0; rd = '0; lat = 0;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen_wb |= mem_writable;
      if (k == 1) a1 = mem_addr;
      if (cpu_ready) begin
        done = 1'b1; lat = k; rd = cpu_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: got no cpu_ready expected ready in %0d cycles", nm, v.lat);
    end else begin
      chk({nm, ".lat"}, 32'(lat), 32'(v.lat));
      if (!v.we) chk({nm, ".rdata"}, rd, v.rd);
      chk({nm, ".wb"}, 32'(seen_wb), 32'(v.wb));
      if (v.lat > 0) chk({nm, ".a1"}, a1, v.a1);
      if (v.pc) chk({nm, ".mem"}, mem[v.paddr[9:2]], v.pval);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    //         we    addr      wdata         lat rdata         a1 (mem_addr cycle1) wb  pc   paddr     pval
    tbl[0]  = '{1'b0, 32'h40, 32'h0,        3, 32'h11223344, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0};
    tbl[1]  = '{1'b0, 32'h44, 32'h0,        0, 32'h55667788, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0};
    tbl[2]  = '{1'b1, 32'h44, 32'hDEADBEEF, 0, 32'h0,        32'h0,  1'b0, 1'b1, 32'h44, 32'h55667788};
    tbl[3]  = '{1'b0, 32'h44, 32'h0,        0, 32'hDEADBEEF, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0};
    tbl[4]  = '{1'b0, 32'hC0, 32'h0,        5, 32'hAAAA0000, 32'h40, 1'b1, 1'b1, 32'h44, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 32'h44, 32'h0,        3, 32'hDEADBEEF, 32'h40, 1'b0, 1'b1, 32'h40, 32'h11223344};
    tbl[6]  = '{1'b0, 32'h40, 32'h0,        0, 32'h11223344, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0};
    tbl[7]  = '{1'b0, 32'hC4, 32'h0,        3, 32'hBBBB1111, 32'hC0, 1'b0, 1'b0, 32'h0,  32'h0};
    tbl[8]  = '{1'b1, 32'h10, 32'h12345678, 3, 32'h0,        32'h10, 1'b0, 1'b1, 32'h10, 32'hA0000010};
    tbl[9]  = '{1'b0, 32'h10, 32'h0,        0, 32'h12345678, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0};
    tbl[10] = '{1'b0, 32'h14, 32'h0,        0, 32'hA0000014, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0};
    tbl[11] = '{1'b0, 32'h90, 32'h0,        5, 32'hA0000090, 32'h10, 1'b1, 1'b1, 32'h10, 32'h12345678};
    tbl[12] = '{1'b0, 32'h14, 32'h0,        3, 32'hA0000014, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0};
    tbl[13] = '{1'b1, 32'hC0, 32'h77777777, 0, 32'h0,        32'h0,  1'b0, 1'b0, 32'h0,  32'h0};

    cpu_req = 1'b1; cpu_addr = 32'h40;
    @(posedge clk); #1;
    tb_init = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(cpu_ready), 32'h0);
    chk("rst.rdata", cpu_rdata, 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.writable", 32'(mem_writable), 32'h0);
    chk("rst.mem_write", mem_write, 32'h0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) access(tbl[i], $sformatf("v%0d", i));

    // Reset while the second write-back beat is on the bus.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(negedge clk);
    chk("wbrst.miss_ready", 32'(cpu_ready), 32'h0);
    @(posedge clk); #1;
    chk("wbrst.wb0_writable", 32'(mem_writable), 32'h1);
    chk("wbrst.wb0_addr", mem_addr, 32'hC0);
    chk("wbrst.wb0_data", mem_write, 32'h77777777);
    @(posedge clk); #1;
    chk("wbrst.wb1_writable", 32'(mem_writable), 32'h1);
    chk("wbrst.wb1_addr", mem_addr, 32'hC4);
    chk("wbrst.wb1_data", mem_write, 32'hBBBB1111);
    rst_n = 1'b0;
    #1;
    chk("wbrst.writable", 32'(mem_writable), 32'h0);
    chk("wbrst.mem_addr", mem_addr, 32'h0);
    chk("wbrst.ready", 32'(cpu_ready), 32'h0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    access('{1'b0, 32'hC0, 32'h0, 3, 32'h77777777, 32'hC0, 1'b0, 1'b1, 32'hC0, 32'h77777777}, "after_rst");

    // Request dropped after the miss cycle: eviction and refill must still finish.
    access('{1'b1, 32'hC4, 32'h55AA55AA, 0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}, "drop_store");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(negedge clk);
    chk("drop.miss_ready", 32'(cpu_ready), 32'h0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("drop.wb1_mem", mem[8'h31], 32'h55AA55AA);
    chk("drop.writable", 32'(mem_writable), 32'h0);
    access('{1'b0, 32'h40, 32'h0, 0, 32'h11223344, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}, "drop_hit0");
    access('{1'b0, 32'h44, 32'h0, 0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}, "drop_hit1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
